// File: rtl/shared_adder_arbiter.sv
// Round-robin arbiter that time-shares one ripple-carry adder among NREQ requesters; SHARED_ADDER_SAT_EN saturates the sum on carry-out.
// Latency: result valid one cycle after the accepting edge; one operation in flight, peak one op per 3 cycles.
// Backpressure: the result is held until rsp_ready_i; no new grant is issued until the response handshake completes.
module shared_adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  ena_i,
  input  logic [NREQ-1:0]       req_valid_i,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic [NREQ-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WIDTH-1:0]      rsp_sum_o,
  output logic                  rsp_cout_o,
  output logic [ID_W-1:0]       rsp_id_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } rsp_t;

  state_t           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [ID_W-1:0]  id_q;
  rsp_t             rsp_q, rsp_d;
  logic             rsp_valid_q;
  logic             busy_q;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [NREQ-1:0]  grant;
  logic             accept;
  logic [ID_W-1:0]  ptr_next;
  logic [WIDTH-1:0] sum_c;
  logic             carry;

  // First valid requester scanning upward from rr_ptr_q, wrapping at NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid_i[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  assign accept   = (state_q == IDLE) && ena_i && found;
  assign grant    = accept ? (NREQ'(1) << winner) : '0;
  assign ptr_next = (winner == ID_W'(NREQ - 1)) ? '0 : winner + ID_W'(1);

  // Reset also masks the combinational grant so nothing transfers while held in reset.
  assign req_ready_o = grant & {NREQ{rst_n_i}};

  // The single shared adder: explicit ripple chain, carry-in 0.
  always_comb begin
    carry = 1'b0;
    sum_c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      sum_c[k] = a_q[k] ^ b_q[k] ^ carry;
      carry    = (a_q[k] & b_q[k]) | (carry & (a_q[k] ^ b_q[k]));
    end
  end

  always_comb begin
    rsp_d.id   = id_q;
    rsp_d.cout = carry;
`ifdef SHARED_ADDER_SAT_EN
    rsp_d.sum  = carry ? {WIDTH{1'b1}} : sum_c;
`else
    rsp_d.sum  = sum_c;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q      <= req_a_i[int'(winner)*WIDTH +: WIDTH];
            b_q      <= req_b_i[int'(winner)*WIDTH +: WIDTH];
            id_q     <= winner;
            rr_ptr_q <= ptr_next;
            busy_q   <= 1'b1;
            state_q  <= ADD;
          end
        end
        ADD: begin
          rsp_q       <= rsp_d;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_sum_o   = rsp_q.sum;
  assign rsp_cout_o  = rsp_q.cout;
  assign rsp_id_o    = rsp_q.id;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Scoreboard bench for shared_adder_arbiter: a reference model predicts grants and pushes expected results at acceptance.
module tb_shared_adder_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int ID_W  = 2;

  logic                  clk = 1'b0;
  logic                  rst_n, ena, rsp_ready;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid, rsp_cout, busy;
  logic [WIDTH-1:0]      rsp_sum;
  logic [ID_W-1:0]       rsp_id;

  always #5 clk = ~clk;

  shared_adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ena_i(ena),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_sum_o(rsp_sum), .rsp_cout_o(rsp_cout), .rsp_id_o(rsp_id), .busy_o(busy)
  );

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic             cout;
    logic [WIDTH-1:0] sum;
  } rsp_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic rsp_t model(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    rsp_t r;
    logic [WIDTH:0] s;
    s      = {1'b0, a} + {1'b0, b};
    r.id   = ID_W'(id);
    r.cout = s[WIDTH];
    r.sum  = s[WIDTH-1:0];
`ifdef SHARED_ADDER_SAT_EN
    if (s[WIDTH]) r.sum = '1;
`endif
    return r;
  endfunction

  rsp_t            sb[$];
  rsp_t            last;
  int              m_state = 0;   // 0 idle, 1 add, 2 resp
  int              m_ptr   = 0;
  int              ops     = 0;
  logic [ID_W-1:0] id_log[$];

  always @(negedge clk) begin
    rsp_t            cur;
    logic [NREQ-1:0] exp_rdy;
    int              w;
    cur = {rsp_id, rsp_cout, rsp_sum};
    if (!rst_n) begin
      m_state = 0;
      m_ptr   = 0;
      sb.delete();
      last    = '0;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_data", cur, 0);
    end else begin
      exp_rdy = '0;
      w       = -1;
      if (m_state == 0 && ena) begin
        for (int k = 0; k < NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && req_valid[idx]) w = idx;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, m_state != 0);
      check("rsp_valid", rsp_valid, m_state == 2);
      if (m_state == 2) begin
        if (sb.size() == 0) check("sb_empty", 1, 0);
        else check("rsp_data", cur, sb[0]);
      end else begin
        check("rsp_hold", cur, last);
      end
      case (m_state)
        0: if (w >= 0) begin
             sb.push_back(model(w, req_a[w*WIDTH +: WIDTH], req_b[w*WIDTH +: WIDTH]));
             m_ptr   = (w + 1) % NREQ;
             m_state = 1;
           end
        1: m_state = 2;
        default: if (rsp_ready) begin
             if (sb.size() > 0) last = sb.pop_front();
             id_log.push_back(rsp_id);
             ops++;
             m_state = 0;
           end
      endcase
    end
  end

  task automatic send(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bit got;
    got = 1'b0;
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (!got) check("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk); #1;
      if (m_state == 0 && sb.size() == 0) done = 1'b1;
    end
    check("done_timeout", done, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int ops0;
    bit seen;
    rst_n = 1'b0; ena = 1'b0; rsp_ready = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ena = 1'b1;

    // single op
    send(2, 4'd3, 4'd4);
    wait_done();
    check("t1_sum", rsp_sum, 7);
    check("t1_cout", rsp_cout, 0);
    check("t1_id", rsp_id, 2);

    // overflow
    send(0, 4'h9, 4'h9);
    wait_done();
`ifdef SHARED_ADDER_SAT_EN
    check("ovf_sum", rsp_sum, 4'hF);
`else
    check("ovf_sum", rsp_sum, 4'h2);
`endif
    check("ovf_cout", rsp_cout, 1);

    // round robin, all valid, fresh random operands every cycle
    pulse_reset();
    ops0 = ops;
    id_log.delete();
    req_valid = '1;
    for (int c = 0; c < 40 && (ops - ops0) < 8; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
        req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, 15));
      end
    end
    req_valid = '0;
    wait_done();
    check("rr_ops", ops - ops0, 8);
    for (int k = 0; k < 8 && k < id_log.size(); k++) check("rr_id", id_log[k], k % NREQ);

    // backpressure
    rsp_ready = 1'b0;
    send(1, 4'd5, 4'd6);
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("bp_valid_seen", seen, 1);
    repeat (6) @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done();
    check("bp_sum", rsp_sum, 11);

    // enable gating
    ena = 1'b0;
    ops0 = ops;
    req_valid = '1;
    repeat (10) @(posedge clk);
    #1 check("ena_no_ops", ops - ops0, 0);
    ena = 1'b1;
    @(negedge clk);
    check("ena_first_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();

    // reset in ADD
    send(3, 4'd1, 4'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstadd_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    req_valid = '1;
    @(negedge clk);
    check("rstadd_grant0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_done();

    // reset in RESP
    rsp_ready = 1'b0;
    send(2, 4'd7, 4'd7);
    @(posedge clk); #1;
    check("rstresp_valid_pre", rsp_valid, 1);
    rst_n = 1'b0;
    #1 check("rstresp_valid", rsp_valid, 0);
    check("rstresp_sum", rsp_sum, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = '1;
    @(negedge clk);
    check("rstresp_grant0", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    wait_done();
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end
endmodule
